// File: rtl/ad9361_spi_pkg.sv
// ad9361_spi_pkg
//  Shared definitions for the AD9361 SPI init sequencer: command opcodes,
//  command-word field positions, error codes, sequencer state encoding and
//  the 24-bit SPI word builder.
package ad9361_spi_pkg;

    // Command opcodes, bits [31:30] of a ROM word
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_WAIT  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    // Command field positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 30;
    localparam int ADDR_HI  = 25;
    localparam int ADDR_LO  = 16;
    localparam int MASK_HI  = 15;
    localparam int MASK_LO  = 8;
    localparam int DATA_HI  = 7;
    localparam int DATA_LO  = 0;
    localparam int TICKS_HI = 23;

    // o_Err_Code values
    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_POLL_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ROM_OVERRUN  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_XFER_LO, S_XFER_HI,
        S_CHECK, S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } seq_state_e;

    // {W/Rb, NB[2:0], 2'b00, addr[9:0], data[7:0]}
    function automatic logic [23:0] spi_word(input logic       wr,
                                             input logic [2:0] nb,
                                             input logic [9:0] addr,
                                             input logic [7:0] data);
        return {wr, nb, 2'b00, addr, data};
    endfunction

endpackage

// File: rtl/ad9361_tick_timer.sv
// ad9361_tick_timer
//  TICK_DIV prescaler plus 24-bit tick down-counter, used for WAIT delays
//  and POLL retry gaps.
//  Ports:
//   i_Clk, i_Rst_L  clock, asynchronous active-low reset
//   load_i          load ticks_i and restart the prescaler
//   ticks_i         number of ticks to count
//   done_o          high in the last counting cycle (or when already empty)
module ad9361_tick_timer #(
    parameter int TICK_DIV = 100
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        load_i,
    input  logic [23:0] ticks_i,
    output logic        done_o
);
    localparam int              PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [23:0]   ticks_q, ticks_d;

    always_comb begin
        pre_d   = pre_q;
        ticks_d = ticks_q;
        if (load_i) begin
            ticks_d = ticks_i;
            pre_d   = PRE_MAX;
        end else if (ticks_q != 24'd0) begin
            if (pre_q == '0) begin
                pre_d   = PRE_MAX;
                ticks_d = ticks_q - 24'd1;
            end else begin
                pre_d = pre_q - 1'b1;
            end
        end
    end

    // Flag the final cycle so the sequencer leaves on the exact boundary
    // instead of one cycle late.
    assign done_o = (ticks_q == 24'd0) || (ticks_q == 24'd1 && pre_q == '0);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            pre_q   <= '0;
            ticks_q <= '0;
        end else begin
            pre_q   <= pre_d;
            ticks_q <= ticks_d;
        end
    end

endmodule

// File: rtl/ad9361_spi_init_seq.sv
// ad9361_spi_init_seq
//  Table-driven AD9361 configuration sequencer. Fetches 32-bit commands
//  (WRITE, WAIT, POLL, END) from a synchronous ROM and drives a 24-bit SPI
//  master through its TX/RX handshake.
//  Ports:
//   i_Clk, i_Rst_L           clock, asynchronous active-low reset
//   i_Start                  pulse: run the table from index 0
//   o_Rom_Addr, i_Rom_Data   command ROM (data valid one cycle after address)
//   o_TX_Word, o_TX_DV       SPI word and strobe to the master
//   i_TX_Ready               master idle
//   i_RX_DV, i_RX_Byte       read-back byte from the master
//   o_Busy, o_Done, o_Error  status
//   o_Err_Code, o_Err_Index  failure cause and failing table index
module ad9361_spi_init_seq
    import ad9361_spi_pkg::*;
#(
    parameter int ROM_AW     = 8,
    parameter int TICK_DIV   = 100,
    parameter int POLL_TRIES = 1000,
    parameter int POLL_GAP   = 10
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Start,
    output logic [ROM_AW-1:0] o_Rom_Addr,
    input  logic [31:0]       i_Rom_Data,
    output logic [23:0]       o_TX_Word,
    output logic              o_TX_DV,
    input  logic              i_TX_Ready,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error,
    output logic [1:0]        o_Err_Code,
    output logic [ROM_AW-1:0] o_Err_Index
);
    localparam int                CW       = $clog2(POLL_TRIES + 1);
    localparam logic [ROM_AW-1:0] LAST_IDX = '1;

    seq_state_e        state_q, state_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [1:0]        op_q, op_d;
    logic [7:0]        mask_q, mask_d;
    logic [7:0]        value_q, value_d;
    logic [23:0]       tx_word_q, tx_word_d;
    logic [7:0]        rx_q, rx_d;
    logic              rx_got_q, rx_got_d;
    logic [CW-1:0]     tries_q, tries_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ROM_AW-1:0] err_index_q, err_index_d;

    logic              tmr_load;
    logic [23:0]       tmr_ticks;
    logic              tmr_done;
    logic              tx_dv;
    logic [1:0]        rom_op;
    logic              unused_rom_bits;

    assign rom_op          = i_Rom_Data[OP_HI:OP_LO];
    assign unused_rom_bits = ^i_Rom_Data[29:26];

    ad9361_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .load_i  (tmr_load),
        .ticks_i (tmr_ticks),
        .done_o  (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        op_d        = op_q;
        mask_d      = mask_q;
        value_d     = value_q;
        tx_word_d   = tx_word_q;
        rx_d        = rx_q;
        rx_got_d    = rx_got_q;
        tries_d     = tries_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        tmr_load    = 1'b0;
        tmr_ticks   = i_Rom_Data[TICKS_HI:0];
        tx_dv       = 1'b0;

        // Read byte may arrive any time during the transfer; only polls care.
        if ((state_q == S_XFER_LO || state_q == S_XFER_HI) && op_q == OP_POLL && i_RX_DV) begin
            rx_d     = i_RX_Byte;
            rx_got_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_Start) begin
                    state_d    = S_FETCH;
                    index_d    = '0;
                    err_code_d = ERR_NONE;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d      = rom_op;
                mask_d    = i_Rom_Data[MASK_HI:MASK_LO];
                value_d   = i_Rom_Data[DATA_HI:DATA_LO];
                tries_d   = '0;
                tx_word_d = spi_word(rom_op == OP_WRITE, 3'b000, i_Rom_Data[ADDR_HI:ADDR_LO],
                                     (rom_op == OP_WRITE) ? i_Rom_Data[DATA_HI:DATA_LO] : 8'h00);
                case (rom_op)
                    OP_WRITE, OP_POLL: state_d = S_ISSUE;
                    OP_WAIT: begin
                        if (i_Rom_Data[TICKS_HI:0] == 24'd0) begin
                            state_d = S_NEXT;
                        end else begin
                            tmr_load = 1'b1;
                            state_d  = S_DELAY;
                        end
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_ISSUE: begin
                if (i_TX_Ready) begin
                    tx_dv    = 1'b1;
                    rx_got_d = 1'b0;
                    if (op_q == OP_POLL) tries_d = tries_q + 1'b1;
                    state_d  = S_XFER_LO;
                end
            end
            S_XFER_LO: if (!i_TX_Ready) state_d = S_XFER_HI;
            S_XFER_HI: begin
                if (i_TX_Ready) begin
                    if (op_q == OP_WRITE)  state_d = S_NEXT;
                    else if (rx_got_q)     state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((rx_q & mask_q) == (value_q & mask_q)) begin
                    state_d = S_NEXT;
                end else if (tries_q == CW'(POLL_TRIES)) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_POLL_TIMEOUT;
                    err_index_d = index_q;
                end else if (POLL_GAP == 0) begin
                    state_d = S_ISSUE;
                end else begin
                    tmr_load  = 1'b1;
                    tmr_ticks = 24'(POLL_GAP);
                    state_d   = S_GAP;
                end
            end
            S_GAP:   if (tmr_done) state_d = S_ISSUE;
            S_DELAY: if (tmr_done) state_d = S_NEXT;
            S_NEXT: begin
                if (index_q == LAST_IDX) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_ROM_OVERRUN;
                    err_index_d = index_q;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            op_q        <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            tx_word_q   <= '0;
            rx_q        <= '0;
            rx_got_q    <= 1'b0;
            tries_q     <= '0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            tx_word_q   <= tx_word_d;
            rx_q        <= rx_d;
            rx_got_q    <= rx_got_d;
            tries_q     <= tries_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
        end
    end

    assign o_Rom_Addr  = index_q;
    assign o_TX_Word   = tx_word_q;
    assign o_TX_DV     = tx_dv;
    assign o_Busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign o_Done      = (state_q == S_DONE) || (state_q == S_ERROR);
    assign o_Error     = (state_q == S_ERROR);
    assign o_Err_Code  = err_code_q;
    assign o_Err_Index = err_index_q;

endmodule

// File: tb/tb_ad9361_spi_init_seq.sv
module tb_ad9361_spi_init_seq;
    localparam int ROM_AW     = 2;
    localparam int TICK_DIV   = 4;
    localparam int POLL_TRIES = 4;
    localparam int POLL_GAP   = 3;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  rom_addr;
    logic [31:0] rom_data;
    logic [23:0] tx_word;
    logic        tx_dv;
    logic        tx_ready = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        busy, done, error;
    logic [1:0]  err_code, err_index;

    ad9361_spi_init_seq #(
        .ROM_AW(ROM_AW), .TICK_DIV(TICK_DIV), .POLL_TRIES(POLL_TRIES), .POLL_GAP(POLL_GAP)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start),
        .o_Rom_Addr(rom_addr), .i_Rom_Data(rom_data),
        .o_TX_Word(tx_word), .o_TX_DV(tx_dv), .i_TX_Ready(tx_ready),
        .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_Busy(busy), .o_Done(done), .o_Error(error),
        .o_Err_Code(err_code), .o_Err_Index(err_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rom_mem [4];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int          total = 0;
    int          bad = 0;
    logic [23:0] words_q[$];
    int          dv_cyc_q[$];
    logic [7:0]  resp_q[$];
    logic [7:0]  ref_resp[$];
    logic [23:0] exp_q[$];
    int          fetch1_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // SPI master model: ready drops after the strobe, a read returns the next
    // queued byte (0 when empty), ready rises when the transfer ends.
    initial begin
        logic [23:0] w;
        int          lat;
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                chk("dv_with_ready", 32'(tx_ready), 32'd1);
                w = tx_word;
                words_q.push_back(w);
                dv_cyc_q.push_back(cyc);
                $display("spi word %h at cycle %0d", w, cyc);
                @(posedge clk); #1 tx_ready = 1'b0;
                lat = $urandom_range(1, 4);
                repeat (lat) @(posedge clk);
                #1;
                if (!w[23]) begin
                    rx_byte = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                    rx_dv = 1'b1;
                    if ($urandom_range(0, 1) == 1) tx_ready = 1'b1;
                    @(posedge clk); #1 rx_dv = 1'b0;
                end
                tx_ready = 1'b1;
            end
        end
    end

    task automatic run_seq(input bit mid_start);
        bit pulsed = 1'b0;
        words_q.delete();
        dv_cyc_q.delete();
        fetch1_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clears_status", 32'({done, error, err_code}), 32'd0);
        for (int n = 0; n < 3000 && !done; n++) begin
            if (rom_addr == 2'd1 && fetch1_cyc < 0) fetch1_cyc = cyc;
            if (mid_start && !pulsed && words_q.size() == 1) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_reaches_done", 32'(done), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    // Reference: walk the table by the command rules, consuming poll replies in order.
    task automatic ref_walk(output bit e_err, output logic [1:0] e_code, output logic [1:0] e_idx);
        int          k;
        bit          fin;
        bit          hit;
        logic [31:0] c;
        logic [7:0]  b;
        k = 0; fin = 1'b0; e_err = 1'b0; e_code = 2'b00; e_idx = 2'd0;
        exp_q.delete();
        for (int i = 0; i < 4 && !fin; i++) begin
            c = rom_mem[i];
            case (c[31:30])
                2'b00: exp_q.push_back({1'b1, 5'b0, c[25:16], c[7:0]});
                2'b01: ;
                2'b10: begin
                    hit = 1'b0;
                    for (int a = 0; a < POLL_TRIES && !hit; a++) begin
                        b = (k < ref_resp.size()) ? ref_resp[k] : 8'h00;
                        k++;
                        exp_q.push_back({1'b0, 5'b0, c[25:16], 8'h00});
                        if ((b & c[15:8]) == (c[7:0] & c[15:8])) hit = 1'b1;
                    end
                    if (!hit) begin
                        e_err = 1'b1; e_code = 2'b01; e_idx = 2'(i); fin = 1'b1;
                    end
                end
                default: fin = 1'b1;
            endcase
            if (!fin && i == 3) begin
                e_err = 1'b1; e_code = 2'b10; e_idx = 2'd3; fin = 1'b1;
            end
        end
    endtask

    typedef struct packed {
        logic [3:0][31:0] rom;      // {entry3, entry2, entry1, entry0}
        logic [3:0][7:0]  resp;     // poll replies, [0] first
        logic [2:0]       n_resp;
        logic             exp_err;
        logic [1:0]       exp_code;
        logic [1:0]       exp_idx;
        logic [2:0]       n_words;
        logic [5:0][23:0] words;    // expected SPI words, [0] first
    } vec_t;

    vec_t        vecs [7];
    bit          e_err;
    logic [1:0]  e_code, e_idx;
    logic [31:0] w, pv;
    int          r;
    logic [7:0]  b;

    initial begin
        vecs[0] = '{rom: {32'h0, 32'hC000_0000, 32'h02A6_000E, 32'h03DF_0001}, resp: 32'h0, n_resp: 3'd0,
                    exp_err: 1'b0, exp_code: 2'b00, exp_idx: 2'd0, n_words: 3'd2,
                    words: {24'h0, 24'h0, 24'h0, 24'h0, 24'h82A60E, 24'h83DF01}};
        vecs[1] = '{rom: {32'h0, 32'hC000_0000, 32'h03DF_0001, 32'h8244_8080}, resp: {8'h00, 8'h81, 8'h00, 8'h00},
                    n_resp: 3'd3, exp_err: 1'b0, exp_code: 2'b00, exp_idx: 2'd0, n_words: 3'd4,
                    words: {24'h0, 24'h0, 24'h83DF01, 24'h024400, 24'h024400, 24'h024400}};
        vecs[2] = '{rom: {32'h0, 32'hC000_0000, 32'h8244_8080, 32'h0010_0055}, resp: 32'h0, n_resp: 3'd0,
                    exp_err: 1'b1, exp_code: 2'b01, exp_idx: 2'd1, n_words: 3'd5,
                    words: {24'h0, 24'h024400, 24'h024400, 24'h024400, 24'h024400, 24'h801055}};
        vecs[3] = '{rom: {32'h0004_0044, 32'h0003_0033, 32'h0002_0022, 32'h0001_0011}, resp: 32'h0, n_resp: 3'd0,
                    exp_err: 1'b1, exp_code: 2'b10, exp_idx: 2'd3, n_words: 3'd4,
                    words: {24'h0, 24'h0, 24'h800444, 24'h800333, 24'h800222, 24'h800111}};
        vecs[4] = '{rom: {32'hC000_0000, 32'h4000_0002, 32'h03FF_00FF, 32'h4000_0000}, resp: 32'h0, n_resp: 3'd0,
                    exp_err: 1'b0, exp_code: 2'b00, exp_idx: 2'd0, n_words: 3'd1,
                    words: {24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h83FFFF}};
        vecs[5] = '{rom: {32'h0, 32'h0, 32'hC000_0000, 32'h81AB_005A}, resp: {8'h0, 8'h0, 8'h0, 8'hAA}, n_resp: 3'd1,
                    exp_err: 1'b0, exp_code: 2'b00, exp_idx: 2'd0, n_words: 3'd1,
                    words: {24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h01AB00}};
        vecs[6] = '{rom: {32'h0, 32'h0, 32'hC000_0000, 32'h8244_8080}, resp: {8'h81, 8'h00, 8'h00, 8'h00},
                    n_resp: 3'd4, exp_err: 1'b0, exp_code: 2'b00, exp_idx: 2'd0, n_words: 3'd4,
                    words: {24'h0, 24'h0, 24'h024400, 24'h024400, 24'h024400, 24'h024400}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'({error, err_code, err_index}), 32'd0);
        chk("rst_tx", 32'({tx_dv, tx_word}), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        rst_l = 1'b1;
        @(negedge clk);

        // Directed table vectors
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) rom_mem[i] = vecs[v].rom[i];
            resp_q.delete();
            for (int i = 0; i < int'(vecs[v].n_resp); i++) resp_q.push_back(vecs[v].resp[i]);
            run_seq(1'b0);
            $display("vector %0d: words=%0d done=%0b error=%0b code=%b index=%0d",
                     v, words_q.size(), done, error, err_code, err_index);
            chk($sformatf("v%0d_word_count", v), 32'(words_q.size()), 32'(vecs[v].n_words));
            for (int j = 0; j < int'(vecs[v].n_words); j++)
                chk($sformatf("v%0d_word%0d", v, j),
                    (j < words_q.size()) ? 32'(words_q[j]) : 32'hFFFF_FFFF, 32'(vecs[v].words[j]));
            chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_code", v), 32'(err_code), 32'(vecs[v].exp_code));
            if (vecs[v].exp_err) chk($sformatf("v%0d_index", v), 32'(err_index), 32'(vecs[v].exp_idx));
        end

        // Reset in the middle of a transfer, then no restart until i_Start
        rom_mem[0] = 32'h03DF_0001; rom_mem[1] = 32'h02A6_000E; rom_mem[2] = 32'hC000_0000; rom_mem[3] = 32'h0;
        resp_q.delete();
        words_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 200 && words_q.size() == 0; n++) @(negedge clk);
        chk("midrst_first_word_seen", 32'(words_q.size()), 32'd1);
        @(negedge clk); rst_l = 1'b0;
        #1;
        chk("midrst_status", 32'({busy, done, error, err_code, err_index}), 32'd0);
        chk("midrst_tx", 32'({tx_dv, tx_word}), 32'd0);
        chk("midrst_addr", 32'(rom_addr), 32'd0);
        @(negedge clk); rst_l = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_stays_idle", 32'({busy, done}), 32'd0);
        for (int n = 0; n < 200 && !tx_ready; n++) @(negedge clk);
        chk("midrst_master_ready", 32'(tx_ready), 32'd1);
        run_seq(1'b0);
        chk("midrst_rerun_count", 32'(words_q.size()), 32'd2);
        if (words_q.size() > 0) chk("midrst_rerun_first", 32'(words_q[0]), 32'h0083DF01);
        chk("midrst_rerun_error", 32'(error), 32'd0);

        // i_Start while busy must not re-run the table
        run_seq(1'b1);
        repeat (30) @(negedge clk);
        chk("busy_start_words", 32'(words_q.size()), 32'd2);
        chk("busy_start_done", 32'({done, busy}), 32'b10);

        // WAIT 5 ticks: WAIT fetch to next fetch = 2 + 5*4 + 1, next strobe 2 later
        rom_mem[0] = 32'h0001_0011; rom_mem[1] = 32'h4000_0005; rom_mem[2] = 32'h0002_0022; rom_mem[3] = 32'hC000_0000;
        run_seq(1'b0);
        chk("wait5_word_count", 32'(words_q.size()), 32'd2);
        if (dv_cyc_q.size() == 2) chk("wait5_latency", 32'(dv_cyc_q[1] - fetch1_cyc), 32'd25);
        // WAIT 0: no tick delay
        rom_mem[1] = 32'h4000_0000;
        run_seq(1'b0);
        chk("wait0_word_count", 32'(words_q.size()), 32'd2);
        if (dv_cyc_q.size() == 2) chk("wait0_latency", 32'(dv_cyc_q[1] - fetch1_cyc), 32'd5);

        // Randomized tables against the reference walk
        for (int it = 0; it < 40; it++) begin
            pv = {2'b10, 30'($urandom)};
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 9);
                w = $urandom;
                if (r < 4) begin
                    w[31:30] = 2'b00;
                end else if (r < 6) begin
                    w[31:30] = 2'b01;
                    w[23:0] = 24'($urandom_range(0, 3));
                end else if (r < 9) begin
                    w[31:30] = 2'b10;
                    pv = w;
                end else begin
                    w[31:30] = 2'b11;
                end
                rom_mem[i] = w;
            end
            resp_q.delete();
            ref_resp.delete();
            for (int j = 0; j < 12; j++) begin
                b = ($urandom_range(0, 1) == 1) ? pv[7:0] : 8'($urandom);
                resp_q.push_back(b);
                ref_resp.push_back(b);
            end
            ref_walk(e_err, e_code, e_idx);
            run_seq(1'b0);
            $display("random %0d: table %h %h %h %h words=%0d error=%0b code=%b",
                     it, rom_mem[0], rom_mem[1], rom_mem[2], rom_mem[3], words_q.size(), error, err_code);
            chk($sformatf("rnd%0d_word_count", it), 32'(words_q.size()), 32'(exp_q.size()));
            for (int j = 0; j < exp_q.size(); j++)
                chk($sformatf("rnd%0d_word%0d", it, j),
                    (j < words_q.size()) ? 32'(words_q[j]) : 32'hFFFF_FFFF, 32'(exp_q[j]));
            chk($sformatf("rnd%0d_error", it), 32'(error), 32'(e_err));
            chk($sformatf("rnd%0d_code", it), 32'(err_code), 32'(e_code));
            if (e_err) chk($sformatf("rnd%0d_index", it), 32'(err_index), 32'(e_idx));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
